// File: rtl/pond_out_fifo_pkg.sv
// Shared pond types and sizing helpers used by the pond output buffer.
package pond_pkg;

    localparam int unsigned POND_DATA_WIDTH        = 16;
    localparam int unsigned POND_OUT_DEPTH_DEFAULT = 4;

    typedef logic [POND_DATA_WIDTH-1:0] pond_word_t;

    // Pointer width: index bits plus one wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pond_out_fifo_ptr.sv
// Wrapping FIFO pointer with an extra wrap bit; clear has priority over increment.
module pond_out_fifo_ptr
    import pond_pkg::*;
#(
    parameter int unsigned DEPTH = POND_OUT_DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_inc,
    output logic [ptr_w(DEPTH)-1:0] o_ptr
);

    localparam int unsigned PW = ptr_w(DEPTH);

    logic [PW-1:0] r_ptr;

    // DEPTH is a power of two, so a plain binary increment wraps the index and toggles the wrap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PW'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/pond_out_fifo.sv
// Elastic output buffer behind the pond tile: drops pushes when full and flags sticky overflow.
// Optional zero-cycle empty bypass is enabled by defining POND_OUT_FIFO_BYPASS_EN.
module pond_out_fifo
    import pond_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = POND_DATA_WIDTH,
    parameter int unsigned DEPTH       = POND_OUT_DEPTH_DEFAULT,
    parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push_valid,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop_ready,
    output logic                         pop_valid,
    output logic [DATA_WIDTH-1:0]        pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         overflow
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_overflow;
    logic [PW-1:0]         w_rd_ptr;
    logic [PW-1:0]         w_wr_ptr;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_bypass;
    logic                  w_bypass_take;
    logic                  w_pop_fire;
    logic                  w_push_acc;

    assign w_empty = (w_rd_ptr == w_wr_ptr);
    assign w_full  = (w_rd_ptr[AW-1:0] == w_wr_ptr[AW-1:0]) && (w_rd_ptr[AW] != w_wr_ptr[AW]);

`ifdef POND_OUT_FIFO_BYPASS_EN
    assign w_bypass = w_empty & push_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word consumed in the same cycle never touches the array.
    assign w_bypass_take = w_bypass & pop_ready;
    assign w_pop_fire    = ~w_empty & pop_ready & ~flush;
    assign w_push_acc    = push_valid & ~flush & ~w_bypass_take & (~w_full | w_pop_fire);

    pond_out_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_inc (w_pop_fire),
        .o_ptr (w_rd_ptr)
    );

    pond_out_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_inc (w_push_acc),
        .o_ptr (w_wr_ptr)
    );

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[w_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Sticky drop flag: only a push into a full buffer with no simultaneous pop sets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_overflow <= 1'b0;
        end else if (push_valid & w_full & ~w_pop_fire) begin
            r_overflow <= 1'b1;
        end
    end

    assign pop_valid   = ~w_empty | w_bypass;
    assign pop_data    = w_bypass ? push_data : r_mem[w_rd_ptr[AW-1:0]];
    assign count       = CW'(w_wr_ptr - w_rd_ptr);
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (count >= CW'(AFULL_LEVEL));
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_pond_out_fifo.sv
// Self-checking bench for pond_out_fifo against a queue-based reference model.
module tb_pond_out_fifo;

    localparam int unsigned DEPTH = 4;
`ifdef POND_OUT_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        push_valid;
    logic [15:0] push_data;
    logic        pop_ready;
    logic        pop_valid;
    logic [15:0] pop_data;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic        overflow;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] q[$];
    logic [15:0] popped[$];
    bit          m_ovf;

    always #5 clk = ~clk;

    pond_out_fifo #(.DATA_WIDTH(16), .DEPTH(DEPTH), .AFULL_LEVEL(DEPTH-1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .pop_ready   (pop_ready),
        .pop_valid   (pop_valid),
        .pop_data    (pop_data),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= DEPTH - 1));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // One clock: drive, check same-cycle outputs, clock, update model, check registered status.
    task automatic cycle(input logic pv, input logic [15:0] pd, input logic pr, input logic fl);
        bit          byp;
        bit          exp_pv;
        logic [15:0] exp_pd;
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        flush      = fl;
        #1;
        byp    = BYP && (q.size() == 0) && pv && !fl;
        exp_pv = (q.size() != 0) || byp;
        exp_pd = byp ? pd : ((q.size() != 0) ? q[0] : 16'h0);
        chk("pop_valid", 32'(pop_valid), 32'(exp_pv));
        if (exp_pv) chk("pop_data", 32'(pop_data), 32'(exp_pd));
        if (pop_valid && pr && !fl) popped.push_back(pop_data);
        @(posedge clk);
        if (fl) begin
            q.delete();
            m_ovf = 1'b0;
        end else if (!byp || !pr) begin
            if (pr && q.size() != 0) void'(q.pop_front());
            if (pv) begin
                if (q.size() < DEPTH) q.push_back(pd);
                else m_ovf = 1'b1;
            end
        end
        #1;
        check_state();
    endtask

    task automatic fill4();
        cycle(1'b1, 16'h0011, 1'b0, 1'b0);
        cycle(1'b1, 16'h0022, 1'b0, 1'b0);
        cycle(1'b1, 16'h0033, 1'b0, 1'b0);
        cycle(1'b1, 16'h0044, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] exp_seq[$];
        rst_n = 1'b0; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
        m_ovf = 1'b0;
        #12;
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        check_state();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset then idle
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);

        // Fill and drain
        fill4();
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_full", 32'(full), 32'd1);
        popped.delete();
        repeat (4) cycle(1'b0, 16'h0, 1'b1, 1'b0);
        exp_seq = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        chk("drain_len", 32'(popped.size()), 32'd4);
        foreach (exp_seq[i]) if (i < popped.size()) chk("drain_word", 32'(popped[i]), 32'(exp_seq[i]));
        chk("drain_empty", 32'(empty), 32'd1);

        // Overflow then flush (flush also discards a concurrent push)
        fill4();
        cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_head", 32'(pop_data), 32'h0011);
        cycle(1'b1, 16'h1234, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_ovf", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop
        fill4();
        popped.delete();
        cycle(1'b1, 16'h0055, 1'b1, 1'b0);
        chk("fpp_count", 32'(count), 32'd4);
        chk("fpp_ovf", 32'(overflow), 32'd0);
        repeat (4) cycle(1'b0, 16'h0, 1'b1, 1'b0);
        exp_seq = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
        chk("fpp_len", 32'(popped.size()), 32'd5);
        foreach (exp_seq[i]) if (i < popped.size()) chk("fpp_word", 32'(popped[i]), 32'(exp_seq[i]));

        // Pointer wrap with back-to-back push/pop
        popped.delete();
        for (int i = 0; i < 10; i++) cycle(1'b1, 16'(i), 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("wrap_len", 32'(popped.size()), 32'd10);
        for (int i = 0; i < 10; i++) if (i < popped.size()) chk("wrap_word", 32'(popped[i]), 32'(i));

        // Push into empty with pop_ready: same cycle with bypass, next cycle without
        popped.delete();
        cycle(1'b1, 16'h00AA, 1'b1, 1'b0);
        chk("byp_count", 32'(count), BYP ? 32'd0 : 32'd1);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("byp_len", 32'(popped.size()), 32'd1);
        if (popped.size() != 0) chk("byp_word", 32'(popped[0]), 32'h00AA);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset mid-transfer
        cycle(1'b1, 16'h0777, 1'b0, 1'b0);
        cycle(1'b1, 16'h0888, 1'b0, 1'b0);
        push_valid = 1'b0; pop_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        chk("arst_pop_valid", 32'(pop_valid), 32'd0);
        check_state();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1'b0, 16'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pond_out_fifo.md
# pond_out_fifo

Elastic output buffer placed directly downstream of the pond memory tile. It captures each word the pond read schedule emits, on the cycles its read-valid strobe is high, and re-presents the words to the fabric with a valid/ready handshake. It reports occupancy and almost-full so the consumer or the configuration controller can detect back-pressure. Words that arrive while the buffer is full are dropped and flagged with a sticky overflow, because the pond schedule cannot stall.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one pond word.
- DEPTH, 4, number of entries; power of two, at least 2.
- AFULL_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  input  1  single clock; all state is updated on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- flush  input  1  synchronous clear of contents and status.
- push_valid  input  1  pond read-schedule valid strobe; the word is written this cycle.
- push_data  input  DATA_WIDTH  pond data_out word.
- pop_ready  input  1  downstream can accept this cycle.
- pop_valid  output  1  pop_data holds a valid word.
- pop_data  output  DATA_WIDTH  head word.
- count  output  $clog2(DEPTH+1)  current occupancy.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= AFULL_LEVEL.
- overflow  output  1  sticky; a push was dropped.

## Operation
- Storage: DEPTH-entry register array with rd_ptr and wr_ptr. Each pointer is $clog2(DEPTH)+1 bits; the extra MSB is the wrap bit.
- Empty/full derivation:
  - empty when the pointers are equal.
  - full when the low bits are equal and the wrap bits differ.
  - count = wr_ptr - rd_ptr, computed modulo 2^(ptrw).
- pop fires when pop_valid & pop_ready. It advances rd_ptr, wrapping from DEPTH-1 to 0 and toggling the wrap bit.
- push is accepted when push_valid & (~full | pop fires). It writes mem[wr_ptr] and advances wr_ptr.
- Full with a simultaneous pop: the push is accepted and count stays at DEPTH.
- Full without a pop: the push is dropped, overflow is set to 1, and the pointers and contents are unchanged.
- overflow stays set until rst_n or flush clears it.
- Empty with a simultaneous push and pop_ready: there is no pop, since pop_valid is 0. The word is stored (unless bypass is enabled, see Configuration).
- flush:
  - Next cycle: pointers are 0, count is 0, overflow is 0.
  - flush overrides a push or pop in the same cycle; that push is discarded and does not set overflow.
- Array contents are not reset. pop_data is a don't-care while pop_valid is 0.
- pop_data = mem[rd_ptr] and pop_valid = ~empty, both combinational from registered state.
- Handshake rule: while pop_valid=1 and pop_ready=0, pop_data stays stable. Pushes never disturb the head entry.

## Timing
- Reset values (rst_n low): pointers 0, pop_valid 0, count 0, empty 1, full 0, almost_full 0, overflow 0. Reset applies immediately, mid-transfer included.
- Push-to-pop_valid latency: 1 cycle. No bypass without the macro.
- Throughput: one push and one pop per cycle, sustained.
- count, full, empty and almost_full are registered-state derived. They update the cycle after the event.

## Configuration
- POND_OUT_FIFO_BYPASS_EN defined:
  - When empty, push_valid=1 and flush=0, pop_valid=1 and pop_data=push_data in the same cycle.
  - If pop_ready=1 that cycle, the word is consumed, nothing is stored, and count stays 0.
  - Otherwise the word is stored as normal.
- Not defined: zero-cycle path absent; behaviour as in Operation, with latency 1.

## Structure
- Shared package pond_pkg:
  - pond_word_t, a DATA_WIDTH logic vector.
  - POND_OUT_DEPTH_DEFAULT constant.
  - ptr-width helper function ptr_w(depth) = $clog2(depth)+1.
- One sub-module: pond_out_fifo_ptr. It is a wrapping pointer counter with wrap bit, inc and clr inputs, and is instantiated for both rd and wr pointers.
- The array and status logic live in the top module.

## Test plan
- Reset then idle: after rst_n release with no stimulus, pop_valid=0, empty=1, count=0, overflow=0.
- Fill and drain: push 0x0011, 0x0022, 0x0033, 0x0044 with pop_ready=0.
  - Expect full=1 and count=4, with almost_full=1 from count=3 on.
  - Then raise pop_ready and expect 0x0011..0x0044 in order, one per cycle, ending with empty=1.
- Overflow: from full, push 0xBEEF with pop_ready=0.
  - Expect overflow=1, count=4, and the head still 0x0011.
  - Then flush and expect count=0 and overflow=0 next cycle.
- Full push+pop: from full with head 0x0011, push 0x0055 with pop_ready=1.
  - Expect 0x0011 popped, count=4 and overflow=0.
  - Draining afterwards yields 0x0022, 0x0033, 0x0044, 0x0055.
- Pointer wrap: run 10 back-to-back push/pop pairs of 0..9 with pop_ready=1. Expect output 0..9 in order with no loss, and the pointers wrapped twice.
- Bypass: with POND_OUT_FIFO_BYPASS_EN, push 0x00AA into an empty buffer with pop_ready=1. Expect pop_valid=1 and pop_data=0x00AA that cycle, and count=0 next cycle. Without the macro, pop_valid rises one cycle later.
